// File: rtl/tbuf_bus_sched_if.sv
// Request/enable bundle between the tristate drivers and tbuf_bus_sched.
// master = requester side, slave = scheduler side.
interface tbuf_bus_sched_if #(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] drv_en;
    logic [OW-1:0]    owner;
    logic             busy;
    logic             turn;

    modport master (output req, input drv_en, input owner, input busy, input turn);
    modport slave  (input req, output drv_en, output owner, output busy, output turn);
endinterface

// File: rtl/tbuf_bus_sched.sv
// Round-robin owner scheduler for a shared tristate net with break-before-make turnaround.
// Optional macro TBUF_SCHED_PARK_EN parks the last owner's enable while idle.
module tbuf_bus_sched #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned TURN_CYC = 2,
    parameter int unsigned HOLD_MAX = 8
) (
    input logic             clk,
    input logic             rst_n,
    tbuf_bus_sched_if.slave bus
);

`ifdef TBUF_SCHED_PARK_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif

    localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned HW = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam int unsigned TW = (TURN_CYC > 2) ? $clog2(TURN_CYC) : 1;

    localparam logic [TW-1:0]    TURN_LOAD = TW'(TURN_CYC - 1);
    localparam logic [HW-1:0]    HOLD_LIM  = (HOLD_MAX == 0) ? '0 : HW'(HOLD_MAX - 1);
    localparam logic [N_REQ-1:0] ONE       = {{(N_REQ-1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    logic [1:0]       r_state,    w_state_d;
    logic [N_REQ-1:0] r_drv_en,   w_drv_en_d;
    logic [OW-1:0]    r_owner,    w_owner_d;
    logic [OW-1:0]    r_ptr,      w_ptr_d;
    logic             r_busy,     w_busy_d;
    logic             r_turn,     w_turn_d;
    logic [HW-1:0]    r_hold,     w_hold_d;
    logic [TW-1:0]    r_turn_cnt, w_turn_cnt_d;
    logic             r_parked,   w_parked_d;

    logic [N_REQ-1:0] w_own_oh;
    logic             w_other;
    logic             w_any;
    logic             w_preempt;
    logic             w_grant;
    logic [OW-1:0]    w_win, w_win_hi, w_win_lo;
    logic             w_hi_any;

    assign w_own_oh  = ONE << r_owner;
    assign w_other   = |(bus.req & ~w_own_oh);
    assign w_any     = |bus.req;
    assign w_preempt = (HOLD_MAX != 0) && w_other && (r_hold >= HOLD_LIM);

    // Lowest requester above the last grant wins; otherwise wrap to the lowest overall,
    // which leaves the previous owner last in line.
    always_comb begin
        w_win_hi = '0;
        w_win_lo = '0;
        w_hi_any = 1'b0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                w_win_lo = OW'(i);
                if (OW'(i) > r_ptr) begin
                    w_win_hi = OW'(i);
                    w_hi_any = 1'b1;
                end
            end
        end
        w_win = w_hi_any ? w_win_hi : w_win_lo;
    end

    always_comb begin
        w_state_d    = r_state;
        w_drv_en_d   = r_drv_en;
        w_owner_d    = r_owner;
        w_ptr_d      = r_ptr;
        w_busy_d     = r_busy;
        w_turn_d     = r_turn;
        w_hold_d     = r_hold;
        w_turn_cnt_d = r_turn_cnt;
        w_parked_d   = r_parked;
        w_grant      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (PARK && r_parked && w_other) begin
                    w_drv_en_d   = '0;
                    w_turn_d     = 1'b1;
                    w_turn_cnt_d = TURN_LOAD;
                    w_state_d    = ST_TURN;
                end else if (w_any) begin
                    w_grant = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (!(&r_hold)) w_hold_d = r_hold + HW'(1);
                if (!bus.req[r_owner] || w_preempt) begin
                    w_busy_d = 1'b0;
                    if (PARK && !w_other) begin
                        w_state_d = ST_IDLE;
                    end else begin
                        w_drv_en_d   = '0;
                        w_turn_d     = 1'b1;
                        w_turn_cnt_d = TURN_LOAD;
                        w_state_d    = ST_TURN;
                    end
                end
            end
            ST_TURN: begin
                if (r_turn_cnt == '0) begin
                    w_turn_d = 1'b0;
                    if (w_any) begin
                        w_grant = 1'b1;
                    end else begin
                        w_state_d  = ST_IDLE;
                        w_drv_en_d = PARK ? w_own_oh : '0;
                    end
                end else begin
                    w_turn_cnt_d = r_turn_cnt - TW'(1);
                end
            end
            default: begin
                w_state_d  = ST_IDLE;
                w_drv_en_d = '0;
                w_busy_d   = 1'b0;
                w_turn_d   = 1'b0;
            end
        endcase

        if (w_grant) begin
            w_state_d  = ST_DRIVE;
            w_drv_en_d = ONE << w_win;
            w_owner_d  = w_win;
            w_ptr_d    = w_win;
            w_busy_d   = 1'b1;
            w_hold_d   = '0;
            w_parked_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_drv_en   <= '0;
            r_owner    <= '0;
            r_ptr      <= OW'(N_REQ - 1);
            r_busy     <= 1'b0;
            r_turn     <= 1'b0;
            r_hold     <= '0;
            r_turn_cnt <= '0;
            r_parked   <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_drv_en   <= w_drv_en_d;
            r_owner    <= w_owner_d;
            r_ptr      <= w_ptr_d;
            r_busy     <= w_busy_d;
            r_turn     <= w_turn_d;
            r_hold     <= w_hold_d;
            r_turn_cnt <= w_turn_cnt_d;
            r_parked   <= w_parked_d;
        end
    end

    assign bus.drv_en = r_drv_en;
    assign bus.owner  = r_owner;
    assign bus.busy   = r_busy;
    assign bus.turn   = r_turn;

endmodule

// File: tb/tb_tbuf_bus_sched.sv
// Directed bench for tbuf_bus_sched: default instance (HOLD_MAX=8) and a HOLD_MAX=0 instance.
module tb_tbuf_bus_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    tbuf_bus_sched_if #(.N_REQ(4)) bus_a ();
    tbuf_bus_sched_if #(.N_REQ(4)) bus_b ();

    tbuf_bus_sched #(.N_REQ(4), .TURN_CYC(2), .HOLD_MAX(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    tbuf_bus_sched #(.N_REQ(4), .TURN_CYC(2), .HOLD_MAX(0)) u_dut_h0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        bus_a.req = '0;
        bus_b.req = '0;
        step();
        rst_n = 1'b1;
    endtask

    // Enables must never overlap on either instance.
    always @(negedge clk) begin
        if (rst_n) begin
            check("onehot_a", 32'($countones(bus_a.drv_en) <= 1), 32'd1);
            check("onehot_b", 32'($countones(bus_b.drv_en) <= 1), 32'd1);
        end
    end

    initial begin
        int          exp_own [5];
        logic [3:0]  e_en;
        exp_own = '{0, 1, 2, 3, 0};
        bus_a.req = '0;
        bus_b.req = '0;

        // Reset state
        #2;
        check("rst_drv_en", 32'(bus_a.drv_en), 32'd0);
        check("rst_owner",  32'(bus_a.owner),  32'd0);
        check("rst_busy",   32'(bus_a.busy),   32'd0);
        check("rst_turn",   32'(bus_a.turn),   32'd0);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_drv_en", 32'(bus_a.drv_en), 32'd0);
            check("idle_busy",   32'(bus_a.busy),   32'd0);
            check("idle_turn",   32'(bus_a.turn),   32'd0);
        end

        // Single grant and release
        bus_a.req = 4'b0010;
        step();
        check("g1_drv_en", 32'(bus_a.drv_en), 32'h2);
        check("g1_owner",  32'(bus_a.owner),  32'd1);
        check("g1_busy",   32'(bus_a.busy),   32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("g1_hold", 32'(bus_a.drv_en), 32'h2);
        end
        bus_a.req = 4'b0000;
        step();
        check("rel_drv_en", 32'(bus_a.drv_en), 32'd0);
        check("rel_busy",   32'(bus_a.busy),   32'd0);
        check("rel_turn1",  32'(bus_a.turn),   32'd1);
        step();
        check("rel_turn2",  32'(bus_a.turn),   32'd1);
        step();
        check("rel_turn_end", 32'(bus_a.turn),   32'd0);
        check("rel_idle_en",  32'(bus_a.drv_en), 32'd0);

        // Round robin with preemption after 8 drive cycles
        do_reset();
        bus_a.req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            e_en = 4'b0001 << exp_own[k];
            check("rr_owner", 32'(bus_a.owner),  32'(exp_own[k]));
            check("rr_grant", 32'(bus_a.drv_en), 32'(e_en));
            check("rr_busy",  32'(bus_a.busy),   32'd1);
            if (k == 4) break;
            for (int j = 1; j < 8; j++) begin
                step();
                check("rr_hold", 32'(bus_a.drv_en), 32'(e_en));
            end
            step();
            check("rr_turn1",   32'(bus_a.turn),   32'd1);
            check("rr_turn1_en", 32'(bus_a.drv_en), 32'd0);
            step();
            check("rr_turn2",   32'(bus_a.turn),   32'd1);
            check("rr_turn2_en", 32'(bus_a.drv_en), 32'd0);
            step();
        end

        // Owner 2 drops as req[3] rises on the same edge
        do_reset();
        bus_a.req = 4'b0100;
        step();
        check("sw_own2", 32'(bus_a.owner), 32'd2);
        step();
        step();
        bus_a.req = 4'b1000;
        step();
        check("sw_turn1", 32'(bus_a.drv_en), 32'd0);
        check("sw_turnf", 32'(bus_a.turn),   32'd1);
        step();
        check("sw_turn2", 32'(bus_a.drv_en), 32'd0);
        step();
        check("sw_grant3", 32'(bus_a.drv_en), 32'h8);
        check("sw_owner3", 32'(bus_a.owner),  32'd3);
        bus_a.req = 4'b0000;
        step();
        step();
        step();
        check("sw_idle", 32'(bus_a.drv_en), 32'd0);

        // Sole requester re-grant waits for a full turnaround
        bus_a.req = 4'b0001;
        step();
        check("sole_grant", 32'(bus_a.drv_en), 32'h1);
        bus_a.req = 4'b0000;
        step();
        check("sole_rel", 32'(bus_a.drv_en), 32'd0);
        bus_a.req = 4'b0001;
        step();
        check("sole_wait_en",   32'(bus_a.drv_en), 32'd0);
        check("sole_wait_turn", 32'(bus_a.turn),   32'd1);
        step();
        check("sole_regrant", 32'(bus_a.drv_en), 32'h1);
        check("sole_owner",   32'(bus_a.owner),  32'd0);

        // HOLD_MAX=0: no preemption while req[1] waits
        do_reset();
        bus_b.req = 4'b0001;
        step();
        check("h0_grant", 32'(bus_b.drv_en), 32'h1);
        bus_b.req = 4'b0011;
        for (int i = 0; i < 50; i++) begin
            step();
            check("h0_hold", 32'(bus_b.drv_en), 32'h1);
        end
        check("h0_turn", 32'(bus_b.turn), 32'd0);

        // Asynchronous reset in the middle of DRIVE
        bus_a.req = 4'b0010;
        step();
        check("ar_pre", 32'(bus_a.drv_en), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_drv_en", 32'(bus_a.drv_en), 32'd0);
        check("ar_busy",   32'(bus_a.busy),   32'd0);
        check("ar_owner",  32'(bus_a.owner),  32'd0);
        check("ar_b_en",   32'(bus_b.drv_en), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
